gerador_duzias: RTL and testbench
=================================

Name: gerador_duzias

Overview:
- Producer end of the dozen-count interface: counts approved bottles passing the conveyor sensor and emits a one-cycle `inc` pulse to the dozen counter for each completed dozen.
- Runs the box-fill handshake: stops the conveyor when a box is full and waits for the operator's box-swap acknowledge before it resumes counting.
- Sits between the bottle sensor / quality gate and the dozen counter.

Parameters:
- GARRAFAS_POR_DUZIA, default 12: bottles per box. Legal range 2..15.

Ports:
- clk  input  1  system clock; all logic is clocked on the rising edge.
- reset  input  1  synchronous, active-low reset (reset=0 resets the block on the next rising clk edge).
- liga  input  1  conveyor run enable from the operator panel; asynchronous to clk.
- sensor_garrafa  input  1  high while a bottle is in front of the sensor; asynchronous to clk.
- aprovada  input  1  quality verdict for the bottle at the sensor; sampled together with the synchronized sensor edge.
- caixa_trocada  input  1  level or pulse from the operator; box replaced.
- inc  output  1  one-cycle pulse; one dozen completed; drives the dozen counter's `inc`.
- motor  output  1  conveyor motor enable.
- caixa_cheia  output  1  high while waiting for box swap.
- garrafas  output  4  bottles in the current box, 0..GARRAFAS_POR_DUZIA-1.
- rejeitadas  output  8  count of rejected bottles; saturates at 255.

Behaviour:
- Reset (reset=0 at a clk edge):
  - inc=0, motor=0, caixa_cheia=0, garrafas=0, rejeitadas=0.
  - Synchronizer flops cleared; state goes to CONTANDO.
  - Reset overrides all other inputs, including mid-handshake.
- Input conditioning:
  - sensor_garrafa passes through 2-flop synchronizer s1→s2, plus history flop s3.
  - Bottle event `ev` = s2 & ~s3: one cycle per bottle, counted on the rising edge only.
  - liga passes through its own 2-flop synchronizer.
  - aprovada is registered alongside s1/s2 so it is aligned with `ev`.
- State machine (registered):
  - CONTANDO:
    - motor = liga_sync; caixa_cheia=0.
    - On `ev` with motor=1 and aprovada=1, garrafas not at max: garrafas+1.
    - On `ev` with motor=1 and aprovada=1, garrafas == GARRAFAS_POR_DUZIA-1: garrafas←0, inc=1 on the next cycle only, next state CHEIA.
    - On `ev` with motor=1 and aprovada=0: rejeitadas+1 (held at 255); garrafas unchanged.
    - `ev` while motor=0 is ignored.
  - CHEIA:
    - motor=0, caixa_cheia=1.
    - All `ev` are ignored; no counting, including rejects.
    - caixa_trocada=1 at a clk edge → CONTANDO.
    - motor re-asserts the cycle after the transition if liga_sync=1.
- Output timing:
  - motor and caixa_cheia are decoded from registered state.
  - inc is a register: exactly one cycle wide, one cycle after the `ev` that completed the dozen; it is never asserted in consecutive cycles.
- Latency:
  - Raw sensor rise to garrafas update: 3 clk edges.
  - Completing rise to inc high: 4 clk edges.
- Boundaries:
  - caixa_trocada held high on entry to CHEIA: CHEIA still lasts at least one cycle, then the block exits.
  - caixa_trocada asserted in CONTANDO: ignored.
  - Sensor held high indefinitely: counts once.
  - Glitch shorter than one clk period: may be missed, never double-counted.
  - liga dropped mid-box: motor=0 and counting halts; garrafas is retained and counting resumes from that value.

Test Plan:
- Reset, liga=1, 12 clean approved sensor pulses, each 5 cycles high / 5 low:
  - garrafas steps 1..11 then 0.
  - inc is high for exactly 1 cycle, 4 edges after the 12th rise.
  - caixa_cheia=1 and motor=0 afterwards.
- In CHEIA, 3 further sensor pulses, then caixa_trocada 1-cycle pulse:
  - garrafas stays 0 and no inc during the pulses.
  - motor=1 two edges after the caixa_trocada edge.
- Mix of 5 approved and 3 rejected pulses:
  - garrafas=5, rejeitadas=3.
  - 260 rejected pulses saturate rejeitadas at 255.
- Sensor held high for 100 cycles: garrafas increments exactly once.
- liga=0 after 6 bottles, 4 pulses sent, then liga=1 and 6 more pulses:
  - motor=0 during the pause and garrafas holds at 6.
  - The 6 pulses after liga=1 complete the dozen: one inc.
- reset=0 for 1 cycle in CHEIA with garrafas=0 and rejeitadas=7:
  - All outputs 0 and state CONTANDO.
  - motor=1 once liga_sync=1.

Source files
------------

// File: rtl/gerador_duzias_if.sv
// Dozen-count producer bus: operator/sensor inputs toward the generator and
// the count/handshake outputs toward the dozen counter and operator panel.
//   liga, sensor_garrafa, aprovada, caixa_trocada : into the generator
//   inc, motor, caixa_cheia, garrafas, rejeitadas  : out of the generator
// master = generator side, slave = environment side.
interface gerador_duzias_if;
  logic       liga;
  logic       sensor_garrafa;
  logic       aprovada;
  logic       caixa_trocada;
  logic       inc;
  logic       motor;
  logic       caixa_cheia;
  logic [3:0] garrafas;
  logic [7:0] rejeitadas;

  modport master (
    input  liga, sensor_garrafa, aprovada, caixa_trocada,
    output inc, motor, caixa_cheia, garrafas, rejeitadas
  );

  modport slave (
    output liga, sensor_garrafa, aprovada, caixa_trocada,
    input  inc, motor, caixa_cheia, garrafas, rejeitadas
  );
endinterface

// File: rtl/gerador_duzias.sv
// gerador_duzias: counts approved bottles seen by the conveyor sensor, pulses
// inc once per completed box, and stops the conveyor until the operator
// swaps the box.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : gerador_duzias_if.master (inputs liga/sensor_garrafa/aprovada/
//           caixa_trocada, outputs inc/motor/caixa_cheia/garrafas/rejeitadas)
module gerador_duzias #(
  parameter int GARRAFAS_POR_DUZIA = 12
) (
  input  logic               clk,
  input  logic               reset,
  gerador_duzias_if.master   bus
);

  localparam logic [3:0] MAX_G = 4'(GARRAFAS_POR_DUZIA - 1);

  typedef enum logic {CONTANDO = 1'b0, CHEIA = 1'b1} estado_t;

  estado_t    estado_q, estado_d;
  // sens: [0]=s1, [1]=s2 (synchronized), [2]=s3 (history for edge detect)
  logic [2:0] sens_q, sens_d;
  logic [1:0] liga_q, liga_d;
  // aprovada delayed by the same two stages as the sensor so it lines up with ev
  logic [1:0] apr_q, apr_d;
  logic [3:0] garrafas_q, garrafas_d;
  logic [7:0] rej_q, rej_d;
  logic       fim_q, fim_d;     // box completed on the previous edge
  logic       inc_q, inc_d;
  logic       motor_q, motor_d;
  logic       cheia_q, cheia_d;
  logic       ev;

  always_comb begin
    sens_d     = {sens_q[1:0], bus.sensor_garrafa};
    liga_d     = {liga_q[0], bus.liga};
    apr_d      = {apr_q[0], bus.aprovada};
    ev         = sens_q[1] & ~sens_q[2];
    estado_d   = estado_q;
    garrafas_d = garrafas_q;
    rej_d      = rej_q;
    fim_d      = 1'b0;

    case (estado_q)
      CONTANDO: begin
        // Bottles are only counted while the belt is actually running.
        if (ev && motor_q) begin
          if (apr_q[1]) begin
            if (garrafas_q == MAX_G) begin
              garrafas_d = '0;
              fim_d      = 1'b1;
              estado_d   = CHEIA;
            end else begin
              garrafas_d = garrafas_q + 4'd1;
            end
          end else if (rej_q != 8'hFF) begin
            rej_d = rej_q + 8'd1;
          end
        end
      end
      CHEIA: begin
        if (bus.caixa_trocada) estado_d = CONTANDO;
      end
      default: estado_d = CONTANDO;
    endcase

    // inc trails the completing edge by one cycle; a new box cannot complete
    // that fast, so inc is never high two cycles in a row.
    inc_d   = fim_q;
    motor_d = (estado_d == CONTANDO) & liga_q[1];
    cheia_d = (estado_d == CHEIA);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q   <= CONTANDO;
      sens_q     <= '0;
      liga_q     <= '0;
      apr_q      <= '0;
      garrafas_q <= '0;
      rej_q      <= '0;
      fim_q      <= 1'b0;
      inc_q      <= 1'b0;
      motor_q    <= 1'b0;
      cheia_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      sens_q     <= sens_d;
      liga_q     <= liga_d;
      apr_q      <= apr_d;
      garrafas_q <= garrafas_d;
      rej_q      <= rej_d;
      fim_q      <= fim_d;
      inc_q      <= inc_d;
      motor_q    <= motor_d;
      cheia_q    <= cheia_d;
    end
  end

  assign bus.inc         = inc_q;
  assign bus.motor       = motor_q;
  assign bus.caixa_cheia = cheia_q;
  assign bus.garrafas    = garrafas_q;
  assign bus.rejeitadas  = rej_q;

endmodule

// File: tb/tb_gerador_duzias.sv
module tb_gerador_duzias;
  localparam int N = 12;

  logic clk = 1'b0;
  logic reset = 1'b0;
  gerador_duzias_if bus();

  gerador_duzias #(.GARRAFAS_POR_DUZIA(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: box contents, rejects, box-full flag, belt enable.
  int m_g = 0, m_r = 0, m_doz = 0;
  bit m_full = 0, m_liga = 0;

  int   inc_total = 0;
  logic inc_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.inc === 1'b1) begin
      inc_total++;
      checks++;
      assert (inc_prev === 1'b0) else begin
        failures++;
        $error("FAIL inc_consecutive observed=%0b expected=0", inc_prev);
      end
    end
    inc_prev = bus.inc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  // One bottle arriving at the sensor, at the model's level of abstraction.
  task automatic model_ev(input bit apr, output bit done);
    done = 0;
    if (!m_liga || m_full) return;
    if (apr) begin
      if (m_g == N - 1) begin m_g = 0; m_full = 1; m_doz++; done = 1; end
      else m_g++;
    end else if (m_r < 255) m_r++;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_garrafas"}, 32'(bus.garrafas), 32'(m_g));
    chk({tag, "_rejeitadas"}, 32'(bus.rejeitadas), 32'(m_r));
    chk({tag, "_cheia"}, 32'(bus.caixa_cheia), 32'(m_full));
    chk({tag, "_motor"}, 32'(bus.motor), 32'(m_liga && !m_full));
  endtask

  // Clean pulse: hi cycles high, lo cycles low; called at a negedge.
  task automatic pulse(input int hi, input int lo, input bit apr);
    bit done;
    int inc_at;
    model_ev(apr, done);
    bus.aprovada = apr;
    bus.sensor_garrafa = 1'b1;
    inc_at = 0;
    for (int c = 1; c <= hi + lo; c++) begin
      @(posedge clk); @(negedge clk);
      if (bus.inc === 1'b1 && inc_at == 0) inc_at = c;
      if (c == hi) bus.sensor_garrafa = 1'b0;
    end
    chk("inc_cycle", 32'(inc_at), done ? 32'd4 : 32'd0);
    check_outs("pulse");
  endtask

  task automatic rpulse(input bit apr);
    pulse($urandom_range(6, 1), $urandom_range(6, 3), apr);
  endtask

  task automatic swap();
    bus.caixa_trocada = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.caixa_trocada = 1'b0;
    m_full = 0;
    @(posedge clk); @(negedge clk);
    chk("swap_motor", 32'(bus.motor), 32'(m_liga));
    chk("swap_cheia", 32'(bus.caixa_cheia), 32'd0);
    idle(2);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    m_g = 0; m_r = 0; m_full = 0;
    chk("rst_inc", 32'(bus.inc), 32'd0);
    chk("rst_motor", 32'(bus.motor), 32'd0);
    chk("rst_cheia", 32'(bus.caixa_cheia), 32'd0);
    chk("rst_garrafas", 32'(bus.garrafas), 32'd0);
    chk("rst_rejeitadas", 32'(bus.rejeitadas), 32'd0);
    idle(4);
    chk("rst_motor_after", 32'(bus.motor), 32'(m_liga));
  endtask

  // Shuffled mix of approved/rejected pulses.
  task automatic mix(input int n_apr, input int n_rej);
    bit seq[$];
    for (int i = 0; i < n_apr; i++) seq.push_back(1'b1);
    for (int i = 0; i < n_rej; i++) seq.push_back(1'b0);
    for (int i = seq.size() - 1; i > 0; i--) begin
      int j;
      bit t;
      j = $urandom_range(i, 0);
      t = seq[i]; seq[i] = seq[j]; seq[j] = t;
    end
    foreach (seq[i]) rpulse(seq[i]);
  endtask

  initial begin
    bus.liga = 1'b0;
    bus.sensor_garrafa = 1'b0;
    bus.aprovada = 1'b0;
    bus.caixa_trocada = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("init_inc", 32'(bus.inc), 32'd0);
    chk("init_motor", 32'(bus.motor), 32'd0);
    chk("init_cheia", 32'(bus.caixa_cheia), 32'd0);
    chk("init_garrafas", 32'(bus.garrafas), 32'd0);
    chk("init_rejeitadas", 32'(bus.rejeitadas), 32'd0);
    reset = 1'b1;
    bus.liga = 1'b1;
    idle(5);
    m_liga = 1;
    chk("liga_motor", 32'(bus.motor), 32'd1);

    // One full box of clean approved pulses
    for (int i = 0; i < N; i++) pulse(5, 5, 1'b1);

    // Pulses in CHEIA are ignored, then the box is swapped
    repeat (3) rpulse($urandom_range(1, 0));
    swap();

    // Reach CHEIA with 7 rejects recorded, then reset mid-handshake
    mix(N - 1, 7);
    rpulse(1'b1);
    chk("pre_reset_rej", 32'(bus.rejeitadas), 32'd7);
    do_reset();

    // 5 approved / 3 rejected, then reject saturation
    mix(5, 3);
    chk("mix_garrafas", 32'(bus.garrafas), 32'd5);
    chk("mix_rej", 32'(bus.rejeitadas), 32'd3);
    repeat (260) rpulse(1'b0);
    chk("rej_sat", 32'(bus.rejeitadas), 32'd255);

    // Sensor held high for 100 cycles counts once
    pulse(100, 4, 1'b1);
    chk("held_garrafas", 32'(bus.garrafas), 32'd6);

    // liga dropped mid-box
    bus.liga = 1'b0;
    idle(4);
    m_liga = 0;
    chk("pause_motor", 32'(bus.motor), 32'd0);
    repeat (4) rpulse($urandom_range(1, 0));
    chk("pause_garrafas", 32'(bus.garrafas), 32'd6);
    bus.liga = 1'b1;
    idle(5);
    m_liga = 1;
    chk("resume_motor", 32'(bus.motor), 32'd1);
    repeat (6) rpulse(1'b1);
    swap();

    // Glitch entirely between clock edges is not counted
    #2 bus.sensor_garrafa = 1'b1;
    #2 bus.sensor_garrafa = 1'b0;
    @(negedge clk);
    idle(5);
    chk("glitch_garrafas", 32'(bus.garrafas), 32'(m_g));

    // caixa_trocada held: ignored in CONTANDO, CHEIA still lasts >= 1 cycle
    bus.caixa_trocada = 1'b1;
    repeat (N - 1) rpulse(1'b1);
    chk("held_swap_cheia", 32'(bus.caixa_cheia), 32'd0);
    begin
      bit done;
      int inc_at, cheia_cycles;
      model_ev(1'b1, done);
      m_full = 0;
      bus.aprovada = 1'b1;
      bus.sensor_garrafa = 1'b1;
      inc_at = 0; cheia_cycles = 0;
      for (int c = 1; c <= 8; c++) begin
        @(posedge clk); @(negedge clk);
        if (bus.inc === 1'b1 && inc_at == 0) inc_at = c;
        if (bus.caixa_cheia === 1'b1) cheia_cycles++;
        if (c == 4) bus.sensor_garrafa = 1'b0;
      end
      chk("held_swap_inc", 32'(inc_at), done ? 32'd4 : 32'd0);
      chk("held_swap_min_cheia", 32'(cheia_cycles >= 1), 32'd1);
      check_outs("held_swap");
    end
    bus.caixa_trocada = 1'b0;

    // Randomized run with occasional box swaps
    for (int i = 0; i < 60; i++) begin
      if (m_full && $urandom_range(1, 0) == 1) swap();
      rpulse($urandom_range(3, 0) != 0);
    end
    idle(3);
    chk("inc_total", 32'(inc_total), 32'(m_doz));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
